montgomery_select_gen: RTL and testbench

- Sequencer that drives the per-iteration select pair (ai, qi) into the bit-serial Montgomery PE array.
- It is the producer side of the PE mux select interface. The PE mux picks 0, B, M or M+B from {ai, qi}; this block generates those selects.
- It shifts operand A out LSB-first, one bit per iteration, and computes the quotient bit qi = t0 XOR (ai AND b0) from the array's running-sum LSB.
- It issues an iteration strobe to the array and signals completion with a start/done handshake.

---
 rtl/montgomery_select_gen.sv | 116 +++++++++++
 tb/tb_montgomery_select_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_select_gen.sv
`default_nettype none
// ============================================================================
//  Module      : montgomery_select_gen
//  Description : Drives the per-iteration (ai, qi) mux selects and the step
//                strobe into a bit-serial Montgomery PE array.
//  Revision    : 1.0 - initial release
// ============================================================================
module montgomery_select_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic             stall,
    input  logic [WIDTH-1:0] a_in,
    input  logic             b0,
    input  logic             t0,
    output logic             ai,
    output logic             qi,
    output logic             step,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_last_iter;

    assign w_last_iter = (r_cnt == c_last_idx);

    // Outputs are decoded from state so reset forces them low immediately.
    always_comb begin
        w_next = r_state;
        ai     = 1'b0;
        qi     = 1'b0;
        step   = 1'b0;
        last   = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                ai   = r_a_sh[0];
                qi   = t0 ^ (r_a_sh[0] & b0);
                step = !stall;
                last = w_last_iter;
                if (!stall && w_last_iter) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (clr) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_cnt   <= '0;
        end else if (clr) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh <= a_in;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        r_a_sh <= r_a_sh >> 1;
                        // Park the counter at zero after the final iteration.
                        r_cnt  <= w_last_iter ? '0 : r_cnt + c_cnt_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_montgomery_select_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_montgomery_select_gen
//  Description : Directed self-checking bench for montgomery_select_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_montgomery_select_gen;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             clr;
    logic             stall;
    logic [WIDTH-1:0] a_in;
    logic             b0;
    logic             t0;
    logic             ai;
    logic             qi;
    logic             step;
    logic             last;
    logic             busy;
    logic             done;

    int n_assert = 0;
    int n_fail   = 0;

    montgomery_select_gen #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .clr   (clr),
        .stall (stall),
        .a_in  (a_in),
        .b0    (b0),
        .t0    (t0),
        .ai    (ai),
        .qi    (qi),
        .step  (step),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ai, input logic e_qi,
                           input logic e_step, input logic e_last,
                           input logic e_busy, input logic e_done);
        chk({tag, ".ai"},   ai,   e_ai);
        chk({tag, ".qi"},   qi,   e_qi);
        chk({tag, ".step"}, step, e_step);
        chk({tag, ".last"}, last, e_last);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".done"}, done, e_done);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called 1 unit after an edge while IDLE; returns in RUN cycle 1.
    task automatic accept(input logic [WIDTH-1:0] a);
        start = 1'b1;
        a_in  = a;
        cyc();
        start = 1'b0;
        a_in  = 8'h5A;
    endtask

    // Eight unstalled iterations followed by the done cycle and return to IDLE.
    task automatic run8(input string tag, input logic [7:0] t0v,
                        input logic [7:0] eai, input logic [7:0] eqi,
                        input int restart_cyc);
        for (int i = 0; i < 8; i++) begin
            t0    = t0v[i];
            start = ((i + 1) == restart_cyc);
            a_in  = 8'h00;
            #1;
            chk_all($sformatf("%s.c%0d", tag, i + 1), eai[i], eqi[i], 1'b1,
                    (i == 7), 1'b1, 1'b0);
            cyc();
            start = 1'b0;
        end
        t0 = 1'b1;
        #1;
        chk_all({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        t0 = 1'b0;
        #1;
        chk_all({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int done_cnt;
        logic [9:0] stall_v;
        logic [9:0] eai_v;
        logic [9:0] t0_v;

        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        stall = 1'b0;
        a_in  = '0;
        b0    = 1'b0;
        t0    = 1'b0;

        // Reset state
        #2;
        chk_all("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        chk_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1: asynchronous reset in the middle of a run
        accept(8'hFF);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_all($sformatf("s1.c%0d", i + 1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc();
        end
        rst_n = 1'b0;
        #1;
        chk_all("s1.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        chk_all("s1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        accept(8'hFF);
        run8("s1.rerun", 8'h00, 8'hFF, 8'h00, 0);

        // 2: A=0xA5, b0=1, t0=0 -> qi follows ai
        b0 = 1'b1;
        accept(8'hA5);
        run8("s2", 8'h00, 8'hA5, 8'hA5, 0);

        // 3: t0 pattern 1,1,0,0,1,0,1,1 with b0=0 then b0=1
        b0 = 1'b0;
        accept(8'hA5);
        run8("s3a", 8'hD3, 8'hA5, 8'hD3, 0);
        b0 = 1'b1;
        accept(8'hA5);
        run8("s3b", 8'hD3, 8'hA5, 8'h76, 0);

        // 4: A=0x03, two stall cycles in iteration 1; qi tracks t0 while stalled
        b0       = 1'b1;
        stall_v  = 10'b00_0000_0011;
        eai_v    = 10'b00_0000_1111;
        t0_v     = 10'b01_0101_0101;
        done_cnt = 0;
        accept(8'h03);
        for (int i = 0; i < 10; i++) begin
            stall = stall_v[i];
            t0    = t0_v[i];
            #1;
            chk_all($sformatf("s4.c%0d", i + 1), eai_v[i], t0_v[i] ^ (eai_v[i] & 1'b1),
                    !stall_v[i], (i == 9), 1'b1, 1'b0);
            cyc();
        end
        stall = 1'b0;
        t0    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (done === 1'b1) done_cnt++;
            if (i == 0) chk("s4.done_c11", done, 1'b1);
            cyc();
        end
        n_assert++;
        assert (done_cnt == 1) else begin
            n_fail++;
            $error("FAIL s4.done_count: observed %0d expected 1", done_cnt);
        end

        // 5: start re-pulsed on RUN cycle 4 is ignored
        b0 = 1'b1;
        accept(8'hA5);
        run8("s5", 8'h00, 8'hA5, 8'hA5, 4);

        // 6: clr together with start on RUN cycle 5
        b0 = 1'b0;
        accept(8'hA5);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("s6.ai_c%0d", i + 1), ai, i[0] ? 1'b0 : 1'b1);
            cyc();
        end
        clr   = 1'b1;
        start = 1'b1;
        a_in  = 8'hFF;
        #1;
        chk_all("s6.c5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        clr   = 1'b0;
        start = 1'b0;
        t0    = 1'b1;
        #1;
        chk_all("s6.cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        #1;
        chk_all("s6.still_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        t0 = 1'b0;
        accept(8'h01);
        run8("s6.after", 8'h00, 8'h01, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
